// File: rtl/ram_pkg.sv
// Shared constants and helpers for the 4-word x 4-bit register RAM stage.
package ram_pkg;

    localparam int RAM_DATA_W = 4;
    localparam int RAM_ADDR_W = 2;
    localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

    // Wrap-around pointer increment: the last address returns to zero.
    function automatic logic [RAM_ADDR_W-1:0] ptr_inc(input logic [RAM_ADDR_W-1:0] ptr);
        if (ptr == RAM_ADDR_W'(RAM_DEPTH - 1)) begin
            return '0;
        end
        return ptr + RAM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram_regfile_2p.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port.
module ram_regfile_2p
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  we_word;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Decode the write enable into one enable per word.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        we_word = '0;
        if (we) begin
            we_word[waddr] = 1'b1;
        end
    end

    // Write the addressed word on the clock edge.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; validity is tracked by the pointers and count.
        for (int i = 0; i < DEPTH; i++) begin
            if (we_word[i]) begin
                mem_q[i] <= wdata;
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ram_fifo4.sv
// First-word-fall-through FIFO built on the register RAM: owns the pointers,
// occupancy count and valid/ready handshakes on both sides.
module ram_fifo4
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              clkOut
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push, pop;
    logic [DATA_W-1:0] mem_rdata;

    // Status flags come straight from the occupancy count.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign wr_ready = ~full;
    assign rd_valid = ~empty;
    assign count    = count_q;

    // A push is refused when full even if a pop happens in the same cycle (no bypass).
    assign push = wr_valid & wr_ready;
    assign pop  = rd_valid & rd_ready;

    // Head word is shown only while valid, so an empty FIFO reads zero.
    assign rd_data = rd_valid ? mem_rdata : '0;

    // LED stage expects the clock echoed like the other RAM-stage blocks.
    assign clkOut = clk;

    ram_regfile_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Next-state for pointers and count from the accepted handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with asynchronous reset that discards the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo4.sv
// Directed bench for ram_fifo4: hand-computed expectations after each edge.
module tb_ram_fifo4;

    logic       clk;
    logic       rst;
    logic [3:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       clk_out;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    ram_fifo4 dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .clkOut   (clk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output against an expected occupancy and head word.
    task automatic expect_state(input string tag, input int cnt, input logic [3:0] head);
        check({tag, ".count"},    {5'd0, count},    8'(cnt));
        check({tag, ".empty"},    {7'd0, empty},    {7'd0, cnt == 0});
        check({tag, ".full"},     {7'd0, full},     {7'd0, cnt == 4});
        check({tag, ".wr_ready"}, {7'd0, wr_ready}, {7'd0, cnt != 4});
        check({tag, ".rd_valid"}, {7'd0, rd_valid}, {7'd0, cnt != 0});
        check({tag, ".rd_data"},  {4'd0, rd_data},  {4'd0, head});
    endtask

    // Drive one cycle of handshake inputs, then sample 1 time unit after the edge.
    task automatic cycle(input logic wv, input logic [3:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
    endtask

    // Occupancy must never exceed the depth.
    always @(negedge clk) begin
        if (started && !rst) begin
            check("count_le_depth", {7'd0, count <= 3'd4}, 8'd1);
        end
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        wr_data  = 4'h0;

        // 1. Reset, no traffic
        @(posedge clk);
        #1;
        expect_state("reset", 0, 4'h0);
        rst = 1'b0;
        started = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        expect_state("idle", 0, 4'h0);

        // 2. Fill, then a refused fifth push
        cycle(1'b1, 4'h3, 1'b0); expect_state("push1", 1, 4'h3);
        cycle(1'b1, 4'h5, 1'b0); expect_state("push2", 2, 4'h3);
        cycle(1'b1, 4'hA, 1'b0); expect_state("push3", 3, 4'h3);
        cycle(1'b1, 4'hC, 1'b0); expect_state("push4", 4, 4'h3);
        cycle(1'b1, 4'hF, 1'b0); expect_state("push_full", 4, 4'h3);

        // 3. Drain in order, then an extra pop while empty
        cycle(1'b0, 4'h0, 1'b1); expect_state("pop1", 3, 4'h5);
        cycle(1'b0, 4'h0, 1'b1); expect_state("pop2", 2, 4'hA);
        cycle(1'b0, 4'h0, 1'b1); expect_state("pop3", 1, 4'hC);
        cycle(1'b0, 4'h0, 1'b1); expect_state("pop4", 0, 4'h0);
        cycle(1'b0, 4'h0, 1'b1); expect_state("pop_empty", 0, 4'h0);

        // 4. Pointer wrap: 3 in/out moves both pointers to 3, then 4 more cross 3->0
        cycle(1'b1, 4'h6, 1'b0); expect_state("wrap_a1", 1, 4'h6);
        cycle(1'b1, 4'h8, 1'b0); expect_state("wrap_a2", 2, 4'h6);
        cycle(1'b1, 4'hB, 1'b0); expect_state("wrap_a3", 3, 4'h6);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_p1", 2, 4'h8);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_p2", 1, 4'hB);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_p3", 0, 4'h0);
        cycle(1'b1, 4'h1, 1'b0); expect_state("wrap_b1", 1, 4'h1);
        cycle(1'b1, 4'h2, 1'b0); expect_state("wrap_b2", 2, 4'h1);
        cycle(1'b1, 4'h3, 1'b0); expect_state("wrap_b3", 3, 4'h1);
        cycle(1'b1, 4'h4, 1'b0); expect_state("wrap_b4", 4, 4'h1);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_q1", 3, 4'h2);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_q2", 2, 4'h3);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_q3", 1, 4'h4);
        cycle(1'b0, 4'h0, 1'b1); expect_state("wrap_q4", 0, 4'h0);

        // 5. Simultaneous push/pop at count=2 and at full
        cycle(1'b1, 4'hD, 1'b0); expect_state("sim_f1", 1, 4'hD);
        cycle(1'b1, 4'hE, 1'b0); expect_state("sim_f2", 2, 4'hD);
        cycle(1'b1, 4'h7, 1'b1); expect_state("sim_pp", 2, 4'hE);
        cycle(1'b0, 4'h0, 1'b1); expect_state("sim_d1", 1, 4'h7);
        cycle(1'b0, 4'h0, 1'b1); expect_state("sim_d2", 0, 4'h0);
        cycle(1'b1, 4'h1, 1'b0); expect_state("full_f1", 1, 4'h1);
        cycle(1'b1, 4'h2, 1'b0); expect_state("full_f2", 2, 4'h1);
        cycle(1'b1, 4'h3, 1'b0); expect_state("full_f3", 3, 4'h1);
        cycle(1'b1, 4'h4, 1'b0); expect_state("full_f4", 4, 4'h1);
        cycle(1'b1, 4'h5, 1'b1); expect_state("full_pp", 3, 4'h2);
        cycle(1'b0, 4'h0, 1'b1); expect_state("full_d1", 2, 4'h3);
        cycle(1'b0, 4'h0, 1'b1); expect_state("full_d2", 1, 4'h4);
        cycle(1'b0, 4'h0, 1'b1); expect_state("full_d3", 0, 4'h0);

        // 6. Asynchronous reset between edges at count=3
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        cycle(1'b1, 4'hC, 1'b0); expect_state("pre_rst", 3, 4'hA);
        #2;
        rst = 1'b1;
        #1;
        expect_state("async_rst", 0, 4'h0);
        #1;
        rst = 1'b0;
        cycle(1'b1, 4'h9, 1'b0); expect_state("post_rst_push", 1, 4'h9);
        cycle(1'b0, 4'h0, 1'b1); expect_state("post_rst_pop", 0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
